// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// Pure declarations; no latency, no backpressure.
// Consumers take their widths from here unless overridden per instance.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF      = 128;
    localparam int DATA_W_DEF      = 128;
    localparam int ADDR_STRIDE_DEF = 16;
    localparam int LEN_W_DEF       = 8;
    localparam int STARVE_MAX_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_burst_gen.sv
// Loader burst engine: captures base/len/dir, walks beat addresses, flags the last beat.
// Latency: capture on start edge, address valid the cycle after; advances one beat per adv_i.
// Backpressure: a cycle without adv_i holds the current beat address and count.
module dmem_arb_burst_gen
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int ADDR_STRIDE = ADDR_STRIDE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              we_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q,  cnt_d;
    logic [LEN_W-1:0]  len_q,  len_d;
    logic              we_q,   we_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        we_d   = we_q;
        if (start_i) begin
            addr_d = base_i;
            cnt_d  = '0;
            // A zero-length request still moves one beat.
            len_d  = (len_i == '0) ? LEN_W'(1) : len_i;
            we_d   = we_i;
        end else if (adv_i) begin
            // Running sum equals base + cnt*stride, wrapping mod 2^ADDR_W.
            addr_d = addr_q + ADDR_W'(ADDR_STRIDE);
            cnt_d  = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            we_q   <= we_d;
        end
    end

    assign addr_o = addr_q;
    assign we_o   = we_q;
    assign last_o = (cnt_q == len_q - LEN_W'(1));

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core LSU (priority) and the burst image loader.
// Latency: beat issues combinationally in the grant cycle; read data registered one cycle later.
// Backpressure: the losing side is held off, starvation counters force the other through after STARVE_MAX.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_STRIDE = ADDR_STRIDE_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_vf,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wd,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [LEN_W-1:0]  l_len,
    input  logic [DATA_W-1:0] l_wd,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_done,
    output logic              l_busy,
    output logic              mem_we,
    output logic              mem_vf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int             SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  SMAX = SW'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [SW-1:0]     c_starve_q, c_starve_d;
    logic [SW-1:0]     l_starve_q, l_starve_d;
    logic              c_rvalid_q, l_rvalid_q, l_done_q;
    logic [DATA_W-1:0] c_rdata_q, l_rdata_q;

    logic              l_start;
    logic              l_force;
    logic [ADDR_W-1:0] bg_addr;
    logic              bg_we;
    logic              bg_last;

    dmem_arb_burst_gen #(
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_burst_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (l_start),
        .base_i  (l_addr),
        .len_i   (l_len),
        .we_i    (l_we),
        .adv_i   (l_gnt),
        .addr_o  (bg_addr),
        .we_o    (bg_we),
        .last_o  (bg_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (l_start)         state_d = BURST;
            BURST:   if (l_gnt && bg_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign l_force = l_req && (l_starve_q == SMAX);

    // Grants are gated by rst_n so the memory port is quiet while reset is held.
    always_comb begin
        c_gnt   = 1'b0;
        l_gnt   = 1'b0;
        l_start = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    c_gnt   = c_req && !l_force;
                    l_start = l_req && !c_gnt;
                end
                BURST: begin
                    c_gnt = c_req && (c_starve_q == SMAX);
                    l_gnt = !c_gnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_vf   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (c_gnt) begin
            mem_we   = c_we;
            mem_vf   = c_vf;
            mem_addr = c_addr;
            mem_wd   = c_wd;
        end else if (l_gnt) begin
            mem_we   = bg_we;
            mem_vf   = 1'b1;
            mem_addr = bg_addr;
            mem_wd   = l_wd;
        end
    end

    always_comb begin
        c_starve_d = '0;
        l_starve_d = '0;
        if (state_q == IDLE) begin
            if (l_req && c_gnt) begin
                l_starve_d = l_starve_q + SW'(1);
            end
        end else if (c_req && !c_gnt) begin
            c_starve_d = c_starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_starve_q <= '0;
            l_starve_q <= '0;
            c_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            l_done_q   <= 1'b0;
            c_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            c_starve_q <= c_starve_d;
            l_starve_q <= l_starve_d;
            c_rvalid_q <= c_gnt && !c_we;
            l_rvalid_q <= l_gnt && !bg_we;
            l_done_q   <= l_gnt && bg_last;
            if (c_gnt && !c_we) begin
                c_rdata_q <= mem_rd;
            end
            if (l_gnt && !bg_we) begin
                l_rdata_q <= mem_rd;
            end
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign l_rvalid = l_rvalid_q;
    assign l_rdata  = l_rdata_q;
    assign l_done   = l_done_q;
    assign l_busy   = (state_q == BURST);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

    localparam int AW = 128;
    localparam int DW = 128;
    localparam int LW = 8;
    localparam int SM = 4;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, c_vf;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd;
    logic          c_gnt, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          l_req, l_we;
    logic [AW-1:0] l_addr;
    logic [LW-1:0] l_len;
    logic [DW-1:0] l_wd;
    logic          l_gnt, l_rvalid, l_done, l_busy;
    logic [DW-1:0] l_rdata;
    logic          mem_we, mem_vf;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] fmem [64];
    logic [DW-1:0] sh   [64];

    int n_chk = 0;
    int n_err = 0;

    bit            m_busy, m_we;
    int            m_cs, m_ls, m_k, m_n;
    logic [AW-1:0] m_base;
    bit            e_crv, e_lrv, e_done;
    logic [DW-1:0] e_crd, e_lrd;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_vf(c_vf), .c_addr(c_addr), .c_wd(c_wd),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_len(l_len), .l_wd(l_wd),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .l_done(l_done), .l_busy(l_busy),
        .mem_we(mem_we), .mem_vf(mem_vf), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = fmem[mem_addr[9:4]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_cs = 0; m_ls = 0; m_k = 0; m_n = 0; m_base = '0;
        e_crv = 0; e_lrv = 0; e_done = 0; e_crd = '0; e_lrd = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_c_gnt"},    128'(c_gnt),    128'(0));
        chk({tag, "_l_gnt"},    128'(l_gnt),    128'(0));
        chk({tag, "_c_rvalid"}, 128'(c_rvalid), 128'(0));
        chk({tag, "_l_rvalid"}, 128'(l_rvalid), 128'(0));
        chk({tag, "_l_done"},   128'(l_done),   128'(0));
        chk({tag, "_l_busy"},   128'(l_busy),   128'(0));
        chk({tag, "_c_rdata"},  c_rdata,        128'(0));
        chk({tag, "_l_rdata"},  l_rdata,        128'(0));
        chk({tag, "_mem_we"},   128'(mem_we),   128'(0));
        chk({tag, "_mem_vf"},   128'(mem_vf),   128'(0));
        chk({tag, "_mem_addr"}, mem_addr,       128'(0));
        chk({tag, "_mem_wd"},   mem_wd,         128'(0));
    endtask

    // One clock: compare the DUT against the model for the current inputs, then advance both.
    task automatic step();
        bit            cg, lg, st, last;
        bit            xwe, xvf;
        logic [AW-1:0] xa;
        logic [DW-1:0] xw;
        @(negedge clk);
        chk("c_rvalid", 128'(c_rvalid), 128'(e_crv));
        if (e_crv) chk("c_rdata", c_rdata, e_crd);
        chk("l_rvalid", 128'(l_rvalid), 128'(e_lrv));
        if (e_lrv) chk("l_rdata", l_rdata, e_lrd);
        chk("l_done", 128'(l_done), 128'(e_done));
        chk("l_busy", 128'(l_busy), 128'(m_busy));

        st = 0; lg = 0;
        if (!m_busy) begin
            cg = c_req && !(l_req && m_ls >= SM);
            st = l_req && !cg;
        end else begin
            cg = c_req && m_cs >= SM;
            lg = !cg;
        end
        xwe = 0; xvf = 0; xa = '0; xw = '0;
        if (cg) begin
            xwe = c_we; xvf = c_vf; xa = c_addr; xw = c_wd;
        end else if (lg) begin
            xwe = m_we; xvf = 1; xa = m_base + 128'(m_k) * 128'(16); xw = l_wd;
        end
        chk("c_gnt", 128'(c_gnt), 128'(cg));
        chk("l_gnt", 128'(l_gnt), 128'(lg));
        chk("excl", 128'(c_gnt & l_gnt), 128'(0));
        chk("mem_we", 128'(mem_we), 128'(xwe));
        chk("mem_vf", 128'(mem_vf), 128'(xvf));
        chk("mem_addr", mem_addr, xa);
        chk("mem_wd", mem_wd, xw);

        last   = lg && (m_k == m_n - 1);
        e_crv  = cg && !c_we;
        e_lrv  = lg && !m_we;
        e_done = last;
        if (cg && !c_we) e_crd = sh[xa[9:4]];
        if (lg && !m_we) e_lrd = sh[xa[9:4]];
        if (xwe) sh[xa[9:4]] = xw;
        if (mem_we) fmem[mem_addr[9:4]] = mem_wd;

        if (!m_busy) begin
            m_cs = 0;
            if (st) begin
                m_busy = 1; m_base = l_addr; m_we = l_we; m_k = 0;
                m_n = (l_len == 0) ? 1 : int'(l_len);
                m_ls = 0;
            end else if (l_req && cg) begin
                m_ls++;
            end else if (!l_req) begin
                m_ls = 0;
            end
        end else begin
            if (!c_req || cg) m_cs = 0;
            else m_cs++;
            if (lg) begin
                m_k++;
                if (last) begin
                    m_busy = 0;
                    m_cs = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        c_req = 0; c_we = 0; c_vf = 0; c_addr = '0; c_wd = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_len = '0; l_wd = '0;
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            fmem[i] = {4{32'(i * 7919 + 1)}};
            sh[i]   = {4{32'(i * 7919 + 1)}};
        end
        idle_in();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        // Core write 131 to addr 0, then read it back.
        c_req = 1; c_we = 1; c_addr = '0; c_wd = 128'd131;
        step();
        c_we = 0; c_wd = '0;
        step();
        c_req = 0;
        step();
        chk("core_rd_131", c_rdata, 128'd131);

        // Loader write burst of 3 beats at 10000.
        l_req = 1; l_we = 1; l_addr = 128'd10000; l_len = 8'd3; l_wd = r128();
        step();
        l_req = 0;
        for (int i = 0; i < 5; i++) begin l_wd = r128(); step(); end

        // Contention in IDLE: core wins STARVE_MAX times, then the burst starts.
        c_req = 1; c_we = 0; c_addr = r128();
        l_req = 1; l_we = 0; l_addr = 128'd4096; l_len = 8'd2;
        for (int i = 0; i < 7; i++) step();
        c_req = 0; l_req = 0;
        for (int i = 0; i < 3; i++) step();

        // Core starvation inside a 10-beat burst.
        l_req = 1; l_we = 1; l_addr = 128'd20000; l_len = 8'd10;
        step();
        l_req = 0; c_req = 1; c_we = 1;
        for (int i = 0; i < 14; i++) begin c_addr = r128(); c_wd = r128(); l_wd = r128(); step(); end
        c_req = 0;
        for (int i = 0; i < 3; i++) step();

        // Address wrap and zero length.
        l_req = 1; l_we = 0; l_addr = '1 - 128'd15; l_len = 8'd2;
        step();
        l_req = 0;
        for (int i = 0; i < 4; i++) step();
        l_req = 1; l_we = 1; l_addr = 128'd512; l_len = 8'd0; l_wd = r128();
        step();
        l_req = 0;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            c_req  = ($urandom_range(0, 99) < 50);
            c_we   = $urandom_range(0, 1) == 1;
            c_vf   = $urandom_range(0, 1) == 1;
            c_addr = r128();
            c_wd   = r128();
            l_req  = ($urandom_range(0, 99) < 30);
            l_we   = $urandom_range(0, 1) == 1;
            l_addr = ($urandom_range(0, 9) == 0) ? ('1 - 128'd15 - 128'(16 * $urandom_range(0, 3))) : r128();
            l_len  = 8'($urandom_range(0, 7));
            l_wd   = r128();
            step();
        end
        idle_in();
        for (int i = 0; i < 12; i++) step();

        // Reset in the middle of a 5-beat burst.
        l_req = 1; l_we = 1; l_addr = 128'd30000; l_len = 8'd5; l_wd = r128();
        step();
        l_req = 0;
        step();
        step();
        rst_n = 0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        chk("midrst_no_done", 128'(l_done), 128'(0));
        chk("midrst_busy", 128'(l_busy), 128'(0));
        rst_n = 1;
        model_reset();
        c_req = 1; c_we = 0; c_addr = 128'd30000;
        step();
        c_req = 0;
        for (int i = 0; i < 3; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
